snn_tu_sched: RTL and testbench

- Time-unit scheduler that sequences one output-neuron block through the presentation of each image.
- Per image it pulses start_core_img, then runs T_STEPS time units. Each time unit is a start_op_nub pulse, a wait for valid_op_nub, a spike sample and a TU_incre pulse.
- Keeps a saturating per-neuron spike count for the image and reports the winning neuron (argmax) at the end.
- Sits between the top-level image sequencer and the output neuron block.

---
 rtl/snn_tu_sched_pkg.sv | 21 ++
 rtl/snn_tu_sched_argmax_seq.sv | 62 ++++++
 rtl/snn_tu_sched.sv | 157 +++++++++++++++
 tb/tb_snn_tu_sched.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_tu_sched_pkg.sv
// Shared state encoding and default sizing for the time-unit scheduler.
package snn_tu_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ADV   = 3'd4,
        ST_ARG   = 3'd5,
        ST_DONE  = 3'd6
    } sched_state_t;

    localparam int N2_DEF      = 8;
    localparam int T_STEPS_DEF = 350;
    localparam int SW_DEF      = 9;
    localparam int CW_DEF      = 8;
    localparam int IW_DEF      = 3;
    localparam int TO_CYC_DEF  = 4095;

endpackage

// File: rtl/snn_tu_sched_argmax_seq.sv
// Sequential argmax: scans one neuron per cycle after start; the lowest index wins ties.
module snn_tu_sched_argmax_seq #(
    parameter int N2 = 8,
    parameter int CW = 8,
    parameter int IW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N2*CW-1:0] counts,
    output logic             done,
    output logic [IW-1:0]    idx,
    output logic [CW-1:0]    max
);

    localparam logic [IW-1:0] LAST = IW'(N2 - 1);

    logic [CW-1:0] cnt_arr [N2];
    logic          active_reg;
    logic [IW-1:0] cur_reg;
    logic [IW-1:0] best_idx_reg;
    logic [CW-1:0] best_cnt_reg;
    logic [CW-1:0] cur_cnt;
    logic          take;

    genvar gi;
    generate
        for (gi = 0; gi < N2; gi++) begin : g_unpack
            assign cnt_arr[gi] = counts[gi*CW +: CW];
        end
    endgenerate

    assign cur_cnt = cnt_arr[cur_reg];
    assign take    = cur_cnt > best_cnt_reg;
    // done/idx/max describe the result including the neuron examined this cycle
    assign done    = active_reg && (cur_reg == LAST);
    assign idx     = take ? cur_reg : best_idx_reg;
    assign max     = take ? cur_cnt : best_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_reg   <= 1'b0;
            cur_reg      <= '0;
            best_idx_reg <= '0;
            best_cnt_reg <= '0;
        end else if (start) begin
            active_reg   <= 1'b1;
            cur_reg      <= '0;
            best_idx_reg <= '0;
            best_cnt_reg <= '0;
        end else if (active_reg) begin
            best_idx_reg <= idx;
            best_cnt_reg <= max;
            if (done) begin
                active_reg <= 1'b0;
            end else begin
                cur_reg <= cur_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snn_tu_sched.sv
// Time-unit scheduler: per image, runs T_STEPS neuron time units, counts spikes, reports argmax.
// Optional WAIT watchdog built when SCHED_TIMEOUT_EN is defined.
module snn_tu_sched
    import snn_tu_sched_pkg::*;
#(
    parameter int N2      = N2_DEF,
    parameter int T_STEPS = T_STEPS_DEF,
    parameter int SW      = SW_DEF,
    parameter int CW      = CW_DEF,
    parameter int IW      = IW_DEF,
    parameter int TO_CYC  = TO_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             img_start,
    output logic             busy,
    output logic             start_core_img,
    output logic             start_op_nub,
    input  logic             valid_op_nub,
    input  logic [N2-1:0]    spike_op_nub,
    output logic             TU_incre,
    output logic [N2*CW-1:0] count_out,
    output logic             img_done,
    output logic [IW-1:0]    winner,
    output logic [CW-1:0]    winner_cnt,
    output logic             no_spike,
    output logic             timeout
);

    sched_state_t  state_reg, state_next;
    logic [SW-1:0] step_reg;
    logic          wait_expire;
    logic          arg_start;
    logic          arg_done;
    logic [IW-1:0] arg_idx;
    logic [CW-1:0] arg_max;

`ifdef SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);
    logic [TW-1:0] wait_cnt_reg;
    logic          timeout_reg;

    assign wait_expire = (state_reg == ST_WAIT) && !valid_op_nub &&
                         (wait_cnt_reg == TW'(TO_CYC - 1));
    assign timeout     = timeout_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            wait_cnt_reg <= (state_reg == ST_WAIT) ? wait_cnt_reg + 1'b1 : '0;
            timeout_reg  <= timeout_reg | wait_expire;
        end
    end
`else
    assign wait_expire = 1'b0;
    // watchdog not built: TO_CYC is never negative, so this is a constant 0
    assign timeout     = (TO_CYC < 0);
`endif

    always_comb begin
        state_next = state_reg;
        arg_start  = 1'b0;
        unique case (state_reg)
            ST_IDLE:  if (img_start) state_next = ST_INIT;
            ST_INIT:  state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (valid_op_nub || wait_expire) state_next = ST_ADV;
            ST_ADV: begin
                if (step_reg == SW'(T_STEPS)) begin
                    state_next = ST_ARG;
                    arg_start  = 1'b1;
                end else begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ARG:   if (arg_done) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each pulse coincides with its state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            step_reg       <= '0;
            busy           <= 1'b0;
            start_core_img <= 1'b0;
            start_op_nub   <= 1'b0;
            TU_incre       <= 1'b0;
            img_done       <= 1'b0;
            winner         <= '0;
            winner_cnt     <= '0;
            no_spike       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            busy           <= (state_next != ST_IDLE);
            start_core_img <= (state_next == ST_INIT);
            start_op_nub   <= (state_next == ST_ISSUE);
            TU_incre       <= (state_next == ST_ADV);
            img_done       <= (state_next == ST_DONE);

            if (state_reg == ST_INIT) begin
                step_reg <= '0;
            end else if (state_reg == ST_WAIT && state_next == ST_ADV) begin
                step_reg <= step_reg + 1'b1;
            end

            if (state_next == ST_INIT) begin
                winner     <= '0;
                winner_cnt <= '0;
                no_spike   <= 1'b0;
            end else if (state_reg == ST_ARG && arg_done) begin
                winner     <= arg_idx;
                winner_cnt <= arg_max;
                no_spike   <= (arg_max == '0);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N2; gi++) begin : g_cnt
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (state_reg == ST_INIT) begin
                    cnt_reg <= '0;
                end else if (state_reg == ST_WAIT && valid_op_nub &&
                             spike_op_nub[gi] && cnt_reg != '1) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign count_out[gi*CW +: CW] = cnt_reg;
        end
    endgenerate

    snn_tu_sched_argmax_seq #(
        .N2 (N2),
        .CW (CW),
        .IW (IW)
    ) u_argmax (
        .clk    (clk),
        .rst    (rst),
        .start  (arg_start),
        .counts (count_out),
        .done   (arg_done),
        .idx    (arg_idx),
        .max    (arg_max)
    );

endmodule

// File: tb/tb_snn_tu_sched.sv
// Bench for snn_tu_sched: two configurations driven by a randomized neuron-block model.
module tb_snn_tu_sched;

    localparam int N2   = 8;
    localparam int IW   = 3;
    localparam int T_A  = 4;
    localparam int CW_A = 8;
    localparam int TO_A = 10;
    localparam int T_B  = 6;
    localparam int CW_B = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                 img_start_a = 1'b0, valid_a = 1'b0;
    logic [N2-1:0]        spike_a = '0;
    logic                 busy_a, core_a, issue_a, tu_a, done_a, nosp_a, to_a;
    logic [N2*CW_A-1:0]   cnt_a;
    logic [IW-1:0]        win_a;
    logic [CW_A-1:0]      wcnt_a;

    logic                 img_start_b = 1'b0, valid_b = 1'b0;
    logic [N2-1:0]        spike_b = '0;
    logic                 busy_b, core_b, issue_b, tu_b, done_b, nosp_b, to_b;
    logic [N2*CW_B-1:0]   cnt_b;
    logic [IW-1:0]        win_b;
    logic [CW_B-1:0]      wcnt_b;

    int n_vec  = 0;
    int n_miss = 0;
    bit exp_to_a = 1'b0;

    snn_tu_sched #(.N2(N2), .T_STEPS(T_A), .SW(9), .CW(CW_A), .IW(IW), .TO_CYC(TO_A)) dut_a (
        .clk(clk), .rst(rst), .img_start(img_start_a), .busy(busy_a),
        .start_core_img(core_a), .start_op_nub(issue_a), .valid_op_nub(valid_a),
        .spike_op_nub(spike_a), .TU_incre(tu_a), .count_out(cnt_a), .img_done(done_a),
        .winner(win_a), .winner_cnt(wcnt_a), .no_spike(nosp_a), .timeout(to_a)
    );

    snn_tu_sched #(.N2(N2), .T_STEPS(T_B), .SW(9), .CW(CW_B), .IW(IW)) dut_b (
        .clk(clk), .rst(rst), .img_start(img_start_b), .busy(busy_b),
        .start_core_img(core_b), .start_op_nub(issue_b), .valid_op_nub(valid_b),
        .spike_op_nub(spike_b), .TU_incre(tu_b), .count_out(cnt_b), .img_done(done_b),
        .winner(win_b), .winner_cnt(wcnt_b), .no_spike(nosp_b), .timeout(to_b)
    );

    task automatic drive(input int sel, input logic st, input logic v, input logic [7:0] s);
        if (sel == 0) begin
            img_start_a = st; valid_a = v; spike_a = s;
        end else begin
            img_start_b = st; valid_b = v; spike_b = s;
        end
    endtask

    task automatic sample(input int sel, output logic b, output logic core, output logic issue,
                          output logic tu, output logic dn, output logic nosp, output logic to,
                          output logic [63:0] cnt, output int win, output int wcnt);
        if (sel == 0) begin
            b = busy_a; core = core_a; issue = issue_a; tu = tu_a; dn = done_a;
            nosp = nosp_a; to = to_a; cnt = 64'(cnt_a); win = int'(win_a); wcnt = int'(wcnt_a);
        end else begin
            b = busy_b; core = core_b; issue = issue_b; tu = tu_b; dn = done_b;
            nosp = nosp_b; to = to_b; cnt = 64'(cnt_b); win = int'(win_b); wcnt = int'(wcnt_b);
        end
    endtask

    // One image: the bench acts as the neuron block (random response delay, optional random
    // spikes, stray valids outside WAIT, ignored img_start while busy) and models the counts.
    task automatic run_image(input string name, input int sel, input int mode, input logic [7:0] pat,
                             input int dmin, input int dmax, input bit drop_first);
        int t_steps, cw, cmax, pend, cyc, exp_lat, n_core, n_issue, n_tu, got, exp_max, exp_win, bad;
        int exp_cnt[N2];
        logic b, core, issue, tu, dn, nosp, to, st, busy1, got_done, fin_nosp, fin_to;
        logic [63:0] cnt, fin_cnt;
        int win, wcnt, fin_win, fin_wcnt;
        logic [7:0] s;
        t_steps = (sel == 0) ? T_A : T_B;
        cw      = (sel == 0) ? CW_A : CW_B;
        cmax    = (1 << cw) - 1;
        foreach (exp_cnt[i]) exp_cnt[i] = 0;
        pend = 0; cyc = 0; exp_lat = 2 + N2; n_core = 0; n_issue = 0; n_tu = 0;
        got_done = 1'b0; busy1 = 1'b0; fin_cnt = '0; fin_win = 0; fin_wcnt = 0;
        fin_nosp = 1'b0; fin_to = 1'b0;
        @(negedge clk);
        drive(sel, 1'b1, 1'b0, 8'($urandom));
        while (!got_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            st = ($urandom_range(0, 3) == 0);
            drive(sel, st, 1'b0, 8'($urandom));
            sample(sel, b, core, issue, tu, dn, nosp, to, cnt, win, wcnt);
            if (cyc == 1) busy1 = b;
            if (core) n_core++;
            if (tu) n_tu++;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    s = (mode != 0) ? 8'($urandom) : pat;
                    drive(sel, st, 1'b1, s);
                    for (int i = 0; i < N2; i++)
                        if (s[i] && exp_cnt[i] < cmax) exp_cnt[i]++;
                end
            end
            if (issue) begin
                n_issue++;
                if (drop_first && n_issue == 1) begin
`ifdef SCHED_TIMEOUT_EN
                    pend = 0;
                    exp_lat += 2 + TO_A;
                    if (sel == 0) exp_to_a = 1'b1;
`else
                    pend = 30;
                    exp_lat += 2 + 30;
`endif
                end else begin
                    pend = $urandom_range(dmin, dmax);
                    exp_lat += 2 + pend;
                end
                if ($urandom_range(0, 1) == 1) drive(sel, st, 1'b1, 8'($urandom));
            end
            if (dn) begin
                got_done = 1'b1;
                fin_cnt = cnt; fin_win = win; fin_wcnt = wcnt; fin_nosp = nosp; fin_to = to;
            end
        end
        drive(sel, 1'b0, 1'b0, 8'h00);

        n_vec++;
        if (!got_done) begin
            n_miss++;
            $display("FAIL %s img_done: not seen within %0d cycles", name, cyc);
        end else begin
            exp_max = 0;
            foreach (exp_cnt[i]) if (exp_cnt[i] > exp_max) exp_max = exp_cnt[i];
            exp_win = 0;
            for (int i = N2 - 1; i >= 0; i--) if (exp_cnt[i] == exp_max) exp_win = i;

            n_vec++;
            if (cyc !== exp_lat) begin
                n_miss++;
                $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat);
            end
            n_vec++;
            if (n_core !== 1) begin
                n_miss++;
                $display("FAIL %s start_core_img pulses: got %0d expected 1", name, n_core);
            end
            n_vec++;
            if (n_issue !== t_steps) begin
                n_miss++;
                $display("FAIL %s start_op_nub pulses: got %0d expected %0d", name, n_issue, t_steps);
            end
            n_vec++;
            if (n_tu !== t_steps) begin
                n_miss++;
                $display("FAIL %s TU_incre pulses: got %0d expected %0d", name, n_tu, t_steps);
            end
            n_vec++;
            if (busy1 !== 1'b1) begin
                n_miss++;
                $display("FAIL %s busy in INIT: got %b expected 1", name, busy1);
            end
            for (int i = 0; i < N2; i++) begin
                got = int'((fin_cnt >> (i * cw)) & 64'(cmax));
                n_vec++;
                if (got !== exp_cnt[i]) begin
                    n_miss++;
                    $display("FAIL %s count[%0d]: got %0d expected %0d", name, i, got, exp_cnt[i]);
                end
            end
            n_vec++;
            if (fin_win !== exp_win) begin
                n_miss++;
                $display("FAIL %s winner: got %0d expected %0d", name, fin_win, exp_win);
            end
            n_vec++;
            if (fin_wcnt !== exp_max) begin
                n_miss++;
                $display("FAIL %s winner_cnt: got %0d expected %0d", name, fin_wcnt, exp_max);
            end
            n_vec++;
            if (fin_nosp !== (exp_max == 0)) begin
                n_miss++;
                $display("FAIL %s no_spike: got %b expected %b", name, fin_nosp, exp_max == 0);
            end
            n_vec++;
            if (fin_to !== ((sel == 0) ? exp_to_a : 1'b0)) begin
                n_miss++;
                $display("FAIL %s timeout: got %b expected %b", name, fin_to, (sel == 0) ? exp_to_a : 1'b0);
            end
        end

        bad = 0;
        repeat (4) begin
            @(negedge clk);
            sample(sel, b, core, issue, tu, dn, nosp, to, cnt, win, wcnt);
            if (b || core || dn || issue) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_miss++;
            $display("FAIL %s idle_after_done: %0d active cycles, expected 0", name, bad);
        end
        $display("image %-14s inst=%0d cycles=%0d winner=%0d cnt=%0d no_spike=%b timeout=%b",
                 name, sel, cyc, fin_win, fin_wcnt, fin_nosp, fin_to);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy_a, core_a, issue_a, tu_a, done_a, nosp_a, to_a} !== 7'b0) begin
            n_miss++;
            $display("FAIL reset_flags_a: got %b expected 0000000",
                     {busy_a, core_a, issue_a, tu_a, done_a, nosp_a, to_a});
        end
        n_vec++;
        if (cnt_a !== '0 || win_a !== '0 || wcnt_a !== '0) begin
            n_miss++;
            $display("FAIL reset_data_a: counts %h winner %0d cnt %0d expected all 0", cnt_a, win_a, wcnt_a);
        end
        n_vec++;
        if ({busy_b, core_b, issue_b, tu_b, done_b, nosp_b, to_b} !== 7'b0 || cnt_b !== '0) begin
            n_miss++;
            $display("FAIL reset_b: flags %b counts %h expected 0",
                     {busy_b, core_b, issue_b, tu_b, done_b, nosp_b, to_b}, cnt_b);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset state checked");
    endtask

    task automatic test_single_spike;
        run_image("single_spike", 0, 0, 8'h04, 2, 2, 1'b0);
    endtask

    task automatic test_no_spike;
        run_image("no_spike", 0, 0, 8'h00, 1, 3, 1'b0);
    endtask

    task automatic test_tie;
        run_image("tie_3_5", 0, 0, 8'h28, 1, 3, 1'b0);
    endtask

    task automatic test_saturation;
        run_image("saturate", 1, 0, 8'h02, 1, 2, 1'b0);
        run_image("saturate_rand", 1, 1, 8'h00, 1, 3, 1'b0);
    endtask

    task automatic test_random;
        for (int k = 0; k < 4; k++) run_image("random_a", 0, 1, 8'h00, 1, 4, 1'b0);
        for (int k = 0; k < 2; k++) run_image("random_b", 1, 1, 8'h00, 1, 4, 1'b0);
    endtask

    task automatic test_reset_mid;
        int n, pend, guard, bad;
        n = 0; pend = 0; guard = 0; bad = 0;
        @(negedge clk); img_start_a = 1'b1;
        @(negedge clk); img_start_a = 1'b0;
        while (n < 2 && guard < 200) begin
            @(negedge clk);
            guard++;
            valid_a = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    valid_a = 1'b1;
                    spike_a = 8'($urandom);
                end
            end
            if (issue_a) begin
                n++;
                pend = 1;
            end
        end
        n_vec++;
        if (n !== 2) begin
            n_miss++;
            $display("FAIL reset_mid step2: reached %0d issues expected 2", n);
        end
        @(negedge clk);
        valid_a = 1'b0;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({busy_a, issue_a, tu_a, done_a} !== 4'b0 || cnt_a !== '0) begin
            n_miss++;
            $display("FAIL reset_mid async_clear: flags %b counts %h expected 0",
                     {busy_a, issue_a, tu_a, done_a}, cnt_a);
        end
        exp_to_a = 1'b0;
        repeat (2) @(negedge clk) if (done_a) bad++;
        rst = 1'b1;
        repeat (5) @(negedge clk) if (done_a || busy_a || core_a) bad++;
        n_vec++;
        if (bad !== 0) begin
            n_miss++;
            $display("FAIL reset_mid stray_activity: %0d cycles, expected 0", bad);
        end
        $display("reset during step 2 applied");
        run_image("after_reset", 0, 1, 8'h00, 1, 3, 1'b0);
    endtask

    task automatic test_wait_bound;
        run_image("wait_hold", 0, 1, 8'h00, 1, 2, 1'b1);
        run_image("after_hold", 0, 0, 8'h81, 1, 2, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_spike();
        test_no_spike();
        test_tie();
        test_saturation();
        test_random();
        test_reset_mid();
        test_wait_bound();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
